cbus_io_target: RTL and testbench

//  C-bus I/O responder (expansion-card end of the system bus). Decodes I/O read/write cycles

---
 rtl/cbus_pkg.sv | 15 +
 rtl/cbus_sync_fifo.sv | 44 ++++
 rtl/cbus_io_target.sv | 171 +++++++++++++++++
 tb/tb_cbus_io_target.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cbus_pkg.sv
// Shared constants for the C-bus I/O target: register indices, STATUS bit positions, FSM states.
package cbus_pkg;
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_IRQMASK = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int ST_RX_NE   = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_TX_OVF  = 2;
  localparam int ST_RX_UNF  = 3;
  localparam int ST_IRQ     = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE} state_e;
endpackage

// File: rtl/cbus_sync_fifo.sv
// Byte FIFO with valid/ready on both sides; a push into a full FIFO is accepted when a pop frees the slot.
module cbus_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         push, pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign pop       = out_valid && out_ready;
  assign in_ready  = !full || out_ready;
  assign push      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end
endmodule

// File: rtl/cbus_io_target.sv
// C-bus I/O responder: decodes strobed I/O cycles, holds IORDY for WAIT_CYC clocks, bridges to byte FIFOs.
// Optional macro CBUS_TGT_IRQ_EN enables the IRQMASK register and ir_o.
module cbus_io_target
  import cbus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h00D0,
  parameter int          WAIT_CYC    = 4,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        sysrst_n,
  input  logic [23:0] ab_i,
  input  logic [15:0] db_i,
  output logic [7:0]  db_o,
  output logic        db_oe,
  input  logic        ior0_i,
  input  logic        iow0_i,
  output logic        iordy_o,
  output logic        iordy_oe,
  output logic        ir_o,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int CW = $clog2(WAIT_CYC + 1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ior_sync, iow_sync;
  logic                   ior_s, iow_s, ior_d, iow_d;
  logic                   start_rd, start_wr, hit, end_cyc, rd_end;
  logic [1:0]             idx_q;
  logic                   is_rd;
  logic [CW-1:0]          cnt;
  logic [7:0]             rd_q, wr_q, rd_mux, scratch, status;
  logic                   apply, tx_push, tx_in_rdy, tx_empty, tx_full;
  logic [7:0]             rx_head;
  logic                   rx_ne, rx_pop, rx_empty, rx_full;
  logic                   tx_ovf, rx_unf;
  logic [1:0]             irq_mask;

  // Strobes idle high, so the synchronizers reset to 1 to avoid a false falling edge.
  always_ff @(posedge clk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      ior_sync <= '1;
      iow_sync <= '1;
      ior_d    <= 1'b1;
      iow_d    <= 1'b1;
    end else begin
      ior_sync <= {ior_sync[SYNC_STAGES-2:0], ior0_i};
      iow_sync <= {iow_sync[SYNC_STAGES-2:0], iow0_i};
      ior_d    <= ior_s;
      iow_d    <= iow_s;
    end
  end

  assign ior_s    = ior_sync[SYNC_STAGES-1];
  assign iow_s    = iow_sync[SYNC_STAGES-1];
  // A falling strobe only starts a cycle while the other strobe is high.
  assign start_rd = ior_d && !ior_s && iow_s;
  assign start_wr = iow_d && !iow_s && ior_s;
  assign hit      = (ab_i[15:3] == BASE_ADDR[15:3]) && (ab_i[0] == BASE_ADDR[0]);
  assign end_cyc  = is_rd ? ior_s : iow_s;
  assign rd_end   = (state_q == S_ACTIVE) && end_cyc && is_rd;

  always_ff @(posedge clk or negedge sysrst_n) begin
    if (!sysrst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if ((start_rd || start_wr) && hit) state_d = S_WAIT;
      S_WAIT:   if (cnt == '0) state_d = S_ACTIVE;
      S_ACTIVE: if (end_cyc) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign iordy_o  = 1'b0;
  assign iordy_oe = (state_q == S_WAIT);
  assign db_oe    = is_rd && (state_q != S_IDLE);
  assign db_o     = db_oe ? rd_q : 8'h00;

  assign status = {3'b000, ir_o, rx_unf, tx_ovf, tx_full, rx_ne};

  always_comb begin
    rd_mux = 8'h00;
    case (ab_i[2:1])
      REG_DATA:    rd_mux = rx_ne ? rx_head : 8'h00;
      REG_STATUS:  rd_mux = status;
      REG_IRQMASK: rd_mux = {6'b0, irq_mask};
      REG_SCRATCH: rd_mux = scratch;
      default:     rd_mux = 8'h00;
    endcase
  end

  assign tx_push = apply && (idx_q == REG_DATA);
  assign rx_pop  = rd_end && (idx_q == REG_DATA) && rx_ne;

  always_ff @(posedge clk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      idx_q   <= '0;
      is_rd   <= 1'b0;
      cnt     <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      apply   <= 1'b0;
      scratch <= '0;
      tx_ovf  <= 1'b0;
      rx_unf  <= 1'b0;
    end else begin
      apply <= (state_q == S_WAIT) && (cnt == '0) && !is_rd;
      if ((state_q == S_IDLE) && (start_rd || start_wr) && hit) begin
        idx_q <= ab_i[2:1];
        is_rd <= start_rd;
        cnt   <= CW'(WAIT_CYC - 1);
        rd_q  <= rd_mux;
      end else if ((state_q == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if ((state_q == S_WAIT) && (cnt == '0) && !is_rd) wr_q <= db_i[7:0];
      if (apply && (idx_q == REG_SCRATCH)) scratch <= wr_q;
      if (tx_push && !tx_in_rdy) tx_ovf <= 1'b1;
      if (rd_end && (idx_q == REG_DATA) && !rx_ne) rx_unf <= 1'b1;
      // Reading STATUS clears the sticky error flags once the host has seen them.
      if (rd_end && (idx_q == REG_STATUS)) begin
        tx_ovf <= 1'b0;
        rx_unf <= 1'b0;
      end
    end
  end

`ifdef CBUS_TGT_IRQ_EN
  logic ir_q;
  always_ff @(posedge clk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      irq_mask <= '0;
      ir_q     <= 1'b0;
    end else begin
      if (apply && (idx_q == REG_IRQMASK)) irq_mask <= wr_q[1:0];
      ir_q <= |(irq_mask & {tx_empty, rx_ne});
    end
  end
  assign ir_o = ir_q;
`else
  assign irq_mask = 2'b00;
  assign ir_o     = 1'b0;
`endif

  cbus_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx (
    .clk(clk), .rst_n(sysrst_n),
    .in_data(wr_q), .in_valid(tx_push), .in_ready(tx_in_rdy),
    .out_data(tx_data), .out_valid(tx_valid), .out_ready(tx_ready),
    .empty(tx_empty), .full(tx_full)
  );

  cbus_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx (
    .clk(clk), .rst_n(sysrst_n),
    .in_data(rx_data), .in_valid(rx_valid), .in_ready(rx_ready),
    .out_data(rx_head), .out_valid(rx_ne), .out_ready(rx_pop),
    .empty(rx_empty), .full(rx_full)
  );

  logic unused_ok;
  assign unused_ok = ^{ab_i[23:16], db_i[15:8], tx_empty, rx_empty, rx_full};
endmodule

// File: tb/tb_cbus_io_target.sv
// Directed bench for cbus_io_target: bus reads/writes, FIFO bridging, flags, IRQ, decode misses, reset.
module tb_cbus_io_target;
  logic        clk = 1'b0;
  logic        sysrst_n;
  logic [23:0] ab_i;
  logic [15:0] db_i;
  logic [7:0]  db_o;
  logic        db_oe, ior0_i, iow0_i, iordy_o, iordy_oe, ir_o;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef CBUS_TGT_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  always #5 clk = ~clk;

  cbus_io_target dut (
    .clk(clk), .sysrst_n(sysrst_n), .ab_i(ab_i), .db_i(db_i), .db_o(db_o), .db_oe(db_oe),
    .ior0_i(ior0_i), .iow0_i(iow0_i), .iordy_o(iordy_o), .iordy_oe(iordy_oe), .ir_o(ir_o),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One bus cycle with a fixed observation window; counts db_oe / iordy_oe cycles.
  task automatic bus(input bit rd, input logic [15:0] a, input logic [7:0] wd,
                     output logic [7:0] rdat, output int oe_cnt, output int rdy_cnt);
    ab_i = {8'h00, a};
    db_i = {8'hEE, wd};
    rdat = 8'h00; oe_cnt = 0; rdy_cnt = 0;
    @(negedge clk);
    if (rd) ior0_i = 1'b0; else iow0_i = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (iordy_oe) rdy_cnt++;
      if (db_oe) begin oe_cnt++; rdat = db_o; end
    end
    ior0_i = 1'b1; iow0_i = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    int oe, rdy;
    bus(1'b1, a, 8'h00, d, oe, rdy);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] x; int oe, rdy;
    bus(1'b0, a, d, x, oe, rdy);
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic tx_pop(output logic [7:0] d);
    d = tx_data; tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int oe, rdy, n;
    sysrst_n = 1'b0; ab_i = '0; db_i = '0; ior0_i = 1'b1; iow0_i = 1'b1;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_db_oe", db_oe, 0);
    chk("rst_iordy_oe", iordy_oe, 0);
    chk("rst_ir", ir_o, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_db_o", db_o, 0);
    sysrst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single write reaches TX with a 4-clock wait
    bus(1'b0, 16'h00D0, 8'h5A, d, oe, rdy);
    chk("t1_wait_cycles", rdy, 4);
    chk("t1_no_drive", oe, 0);
    chk("t1_tx_valid", tx_valid, 1);
    chk("t1_tx_data", tx_data, 8'h5A);
    tx_pop(d);
    chk("t1_tx_drained", tx_valid, 0);

    // 2: RX bytes read in order, then underflow
    rx_push(8'h11);
    rx_push(8'h22);
    bus(1'b1, 16'h00D0, 8'h00, d, oe, rdy);
    chk("t2_rd0", d, 8'h11);
    chk("t2_rd0_wait", rdy, 4);
    chk("t2_rd0_oe", oe > 0, 1);
    chk("t2_oe_released", db_oe, 0);
    rd(16'h00D0, d); chk("t2_rd1", d, 8'h22);
    rd(16'h00D0, d); chk("t2_rd_empty", d, 8'h00);
    rd(16'h00D2, d); chk("t2_status_unf", d, 8'h08);
    rd(16'h00D2, d); chk("t2_status_clr", d, 8'h00);

    // 3: TX overflow with the card stalled
    for (int i = 1; i <= 5; i++) wr(16'h00D0, 8'(i));
    rd(16'h00D2, d); chk("t3_status_ovf", d, 8'h06);
    rd(16'h00D2, d); chk("t3_status_clr", d, 8'h02);
    for (int i = 1; i <= 4; i++) begin
      tx_pop(d);
      chk($sformatf("t3_tx%0d", i), d, 8'(i));
    end
    chk("t3_tx_empty", tx_valid, 0);

    // 3b: scratch round trip
    wr(16'h00D6, 8'hA5);
    rd(16'h00D6, d); chk("t3_scratch", d, 8'hA5);

    // 4: interrupt on rx_nonempty
    wr(16'h00D4, 8'h01);
    rd(16'h00D4, d); chk("t4_irqmask", d, IRQ ? 8'h01 : 8'h00);
    chk("t4_ir_idle", ir_o, 0);
    rx_push(8'h99);
    repeat (2) @(negedge clk);
    chk("t4_ir_set", ir_o, IRQ);
    rd(16'h00D2, d); chk("t4_status", d, IRQ ? 8'h11 : 8'h01);

    // 5: decode misses and simultaneous strobes
    bus(1'b1, 16'h00D1, 8'h00, d, oe, rdy);
    chk("t5_odd_oe", oe, 0); chk("t5_odd_rdy", rdy, 0);
    bus(1'b1, 16'h00E0, 8'h00, d, oe, rdy);
    chk("t5_far_oe", oe, 0); chk("t5_far_rdy", rdy, 0);
    ab_i = 24'h0000D0; db_i = 16'h0033; oe = 0; rdy = 0;
    @(negedge clk);
    ior0_i = 1'b0; iow0_i = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (db_oe) oe++;
      if (iordy_oe) rdy++;
    end
    ior0_i = 1'b1; iow0_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_both_oe", oe, 0); chk("t5_both_rdy", rdy, 0);
    chk("t5_both_tx", tx_valid, 0);
    rd(16'h00D2, d); chk("t5_rx_kept", d[0], 1);

    // 6: async reset during the wait phase of a read
    wr(16'h00D0, 8'h77);
    chk("t6_tx_pre", tx_valid, 1);
    ab_i = 24'h0000D2;
    @(negedge clk);
    ior0_i = 1'b0;
    n = 0;
    while (!iordy_oe && n < 20) begin @(negedge clk); n++; end
    chk("t6_wait_seen", iordy_oe, 1);
    chk("t6_drive_seen", db_oe, 1);
    #2 sysrst_n = 1'b0;
    #1;
    chk("t6_db_oe_rst", db_oe, 0);
    chk("t6_iordy_rst", iordy_oe, 0);
    ior0_i = 1'b1;
    repeat (3) @(negedge clk);
    sysrst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_tx_empty", tx_valid, 0);
    chk("t6_ir_rst", ir_o, 0);
    rd(16'h00D2, d); chk("t6_status", d, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
